// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU responder: opcodes, FSM states and
// the arithmetic-opcode predicate used by both the slice and the top.
package alu_pkg;

    typedef enum logic [2:0] {
        OPC_ADD  = 3'd0,
        OPC_SUB  = 3'd1,
        OPC_AND  = 3'd2,
        OPC_OR   = 3'd3,
        OPC_XOR  = 3'd4,
        OPC_NOT  = 3'd5,
        OPC_XNOR = 3'd6,
        OPC_RSVD = 3'd7
    } opc_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_arith(input opc_e opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational STEP-bit ALU slice; the carry chain is threaded through
// successive slices by the serial top.
module alu_slice
    import alu_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] a_s,
    input  logic [STEP-1:0] b_s,
    input  logic            carry_in,
    input  opc_e            opc,
    output logic [STEP-1:0] r_s,
    output logic            carry_out
);

    logic [STEP-1:0] b_eff_s;
    logic [STEP:0]   sum_s;

    // Slice result and carry; subtraction adds the inverted operand and the
    // top pre-loads the inverted borrow as the initial carry.
    always_comb begin
        b_eff_s   = (opc == OPC_SUB) ? ~b_s : b_s;
        sum_s     = {1'b0, a_s} + {1'b0, b_eff_s} + {{STEP{1'b0}}, carry_in};
        carry_out = carry_in;
        r_s       = {STEP{1'b0}};
        case (opc)
            OPC_ADD, OPC_SUB: begin
                r_s       = sum_s[STEP-1:0];
                carry_out = sum_s[STEP];
            end
            OPC_AND:  r_s = a_s & b_s;
            OPC_OR:   r_s = a_s | b_s;
            OPC_XOR:  r_s = a_s ^ b_s;
            OPC_NOT:  r_s = ~a_s;
            OPC_XNOR: r_s = ~(a_s ^ b_s);
            default:  r_s = {STEP{1'b0}};
        endcase
    end

endmodule

// File: rtl/serial_alu_responder.sv
// Bit-serial ALU with request/response handshakes: accepts one operation,
// processes STEP bits per cycle LSB first, then holds the result until taken.
module serial_alu_responder
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       opc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    if ((STEP < 1) || ((WIDTH % STEP) != 0)) begin : g_bad_step
        $error("serial_alu_responder: STEP must divide WIDTH");
    end

    state_e           state_r, state_nxt_s;
    logic [WIDTH-1:0] a_sh_r, b_sh_r, acc_r, acc_nxt_s;
    opc_e             opc_r;
    logic             carry_r, zero_acc_r, zero_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             last_s;
    logic [STEP-1:0]  slice_r_s;
    logic             slice_c_s;

    alu_slice #(.STEP(STEP)) u_slice (
        .a_s       (a_sh_r[STEP-1:0]),
        .b_s       (b_sh_r[STEP-1:0]),
        .carry_in  (carry_r),
        .opc       (opc_r),
        .r_s       (slice_r_s),
        .carry_out (slice_c_s)
    );

    // Held low throughout reset so an initiator never sees a stale ready.
    assign req_ready = (state_r == ST_IDLE) && !rst;
    assign last_s    = (cnt_r == CNT_W'(NSTEPS - 1));

    // Next-state logic for the request/run/response sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_nxt_s = ST_RUN;
                else           state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (rsp_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // New slice bits enter at the top so the first (LSB) slice lands in bit 0.
    always_comb begin
        acc_nxt_s = acc_r >> STEP;
        for (int i = 0; i < STEP; i++) begin
            acc_nxt_s[WIDTH-STEP+i] = slice_r_s[i];
        end
        zero_nxt_s = zero_acc_r && (slice_r_s == {STEP{1'b0}});
    end

    // Operand shifters, serial accumulators and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r     <= {WIDTH{1'b0}};
            b_sh_r     <= {WIDTH{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            opc_r      <= OPC_ADD;
            carry_r    <= 1'b0;
            zero_acc_r <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
            result     <= {WIDTH{1'b0}};
            cout       <= 1'b0;
            zero       <= 1'b0;
            neg        <= 1'b0;
            rsp_valid  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_sh_r     <= a;
                        b_sh_r     <= b;
                        opc_r      <= opc_e'(opc);
                        carry_r    <= (opc_e'(opc) == OPC_SUB) ? !cin : cin;
                        zero_acc_r <= 1'b1;
                        cnt_r      <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    a_sh_r     <= a_sh_r >> STEP;
                    b_sh_r     <= b_sh_r >> STEP;
                    acc_r      <= acc_nxt_s;
                    carry_r    <= slice_c_s;
                    zero_acc_r <= zero_nxt_s;
                    cnt_r      <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        result    <= acc_nxt_s;
                        cout      <= is_arith(opc_r) ? slice_c_s : 1'b0;
                        zero      <= zero_nxt_s;
                        neg       <= acc_nxt_s[WIDTH-1];
                        rsp_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_responder.sv
// Self-checking bench: directed scenarios on a STEP=1 build, randomized
// streams on STEP=1 and STEP=4 builds against an arithmetic reference model.
module tb_serial_alu_responder;

    logic        clk = 1'b0;
    logic        rst, req_v, rsp_r, sel;
    logic [15:0] a, b;
    logic        cin;
    logic [2:0]  opc;

    logic        rr1, rv1, co1, z1, n1, rr4, rv4, co4, z4, n4;
    logic [15:0] res1, res4;
    logic        req_ready, rsp_valid, cout, zero, neg;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_alu_responder #(.WIDTH(16), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_v && !sel), .req_ready(rr1),
        .a(a), .b(b), .cin(cin), .opc(opc), .rsp_valid(rv1),
        .rsp_ready(rsp_r && !sel), .result(res1), .cout(co1), .zero(z1), .neg(n1)
    );

    serial_alu_responder #(.WIDTH(16), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_v && sel), .req_ready(rr4),
        .a(a), .b(b), .cin(cin), .opc(opc), .rsp_valid(rv4),
        .rsp_ready(rsp_r && sel), .result(res4), .cout(co4), .zero(z4), .neg(n4)
    );

    assign req_ready = sel ? rr4  : rr1;
    assign rsp_valid = sel ? rv4  : rv1;
    assign result    = sel ? res4 : res1;
    assign cout      = sel ? co4  : co1;
    assign zero      = sel ? z4   : z1;
    assign neg       = sel ? n4   : n1;

    // Reference: {result, cout, zero, neg} from plain integer arithmetic.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic [2:0] mop);
        logic [16:0] t;
        logic [15:0] r;
        logic        co;
        t  = 17'd0;
        r  = 16'd0;
        co = 1'b0;
        case (mop)
            3'd0: begin t = {1'b0, ma} + {1'b0, mb} + {16'd0, mc}; r = t[15:0]; co = t[16]; end
            3'd1: begin t = {1'b0, ma} - {1'b0, mb} - {16'd0, mc}; r = t[15:0]; co = !t[16]; end
            3'd2: r = ma & mb;
            3'd3: r = ma | mb;
            3'd4: r = ma ^ mb;
            3'd5: r = ~ma;
            3'd6: r = ~(ma ^ mb);
            default: r = 16'd0;
        endcase
        return {r, co, (r == 16'd0), r[15]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] oa, input logic [15:0] ob,
                            input logic oc, input logic [2:0] oop, output bit tmo);
        int n;
        n = 0;
        a = oa; b = ob; cin = oc; opc = oop; req_v = 1'b1;
        while (!req_ready && n < 50) begin tick(); n++; end
        tmo = !req_ready;
        tick();
        req_v = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); opc = 3'($urandom);
    endtask

    task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                          input logic [2:0] oop, output logic [18:0] obs, output int lat,
                          output bit tmo);
        bit t0;
        start_op(oa, ob, oc, oop, t0);
        lat = 0;
        while (!rsp_valid && lat < 100) begin tick(); lat++; end
        tmo = t0 || !rsp_valid;
        obs = {result, cout, zero, neg};
        rsp_r = 1'b1;
        tick();
        rsp_r = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_v = 1'b0; rsp_r = 1'b0; sel = 1'b0;
        a = 16'd0; b = 16'd0; cin = 1'b0; opc = 3'd0;
        tick(); tick();
        checks++;
        if ({req_ready, rsp_valid, result, cout, zero, neg} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", {req_ready, rsp_valid, result, cout, zero, neg});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_add();
        logic [18:0] obs;
        int lat;
        bit tmo;
        run_op(16'hFFFF, 16'h0001, 1'b0, 3'd0, obs, lat, tmo);
        checks++;
        if (tmo || obs !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_wrap got=%h exp=%h tmo=%0d", obs, {16'h0000, 3'b110}, tmo);
        end
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL add_latency got=%0d exp=16", lat);
        end
    endtask

    task automatic test_sub();
        logic [18:0] obs;
        int lat;
        bit tmo;
        run_op(16'h0003, 16'h0005, 1'b0, 3'd1, obs, lat, tmo);
        checks++;
        if (tmo || obs !== {16'hFFFE, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_borrow got=%h exp=%h", obs, {16'hFFFE, 3'b001});
        end
        run_op(16'h0003, 16'h0005, 1'b1, 3'd1, obs, lat, tmo);
        checks++;
        if (tmo || obs !== {16'hFFFD, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_cin got=%h exp=%h", obs, {16'hFFFD, 3'b001});
        end
    endtask

    task automatic test_logic();
        logic [15:0] exp_r [2:7];
        logic [18:0] obs, e;
        int lat;
        bit tmo;
        exp_r[2] = 16'h0F00; exp_r[3] = 16'hFFF0; exp_r[4] = 16'hF0F0;
        exp_r[5] = 16'h00FF; exp_r[6] = 16'h0F0F; exp_r[7] = 16'h0000;
        for (int op = 2; op < 8; op++) begin
            run_op(16'hFF00, 16'h0FF0, 1'b1, 3'(op), obs, lat, tmo);
            e = {exp_r[op], 1'b0, (exp_r[op] == 16'h0000), exp_r[op][15]};
            checks++;
            if (tmo || obs !== e) begin
                errors++;
                $display("FAIL logic_op%0d got=%h exp=%h", op, obs, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] obs, e;
        int lat, n, bad;
        bit tmo;
        e = model(16'h1357, 16'h2468, 1'b1, 3'd0);
        start_op(16'h1357, 16'h2468, 1'b1, 3'd0, tmo);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            req_v = (i < 2); rsp_r = (i == 1);
            a = 16'hAAAA; b = 16'h5555; opc = 3'd4;
            if (req_ready !== 1'b0) bad++;
        end
        req_v = 1'b0; rsp_r = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin tick(); n++; end
        checks++;
        if (tmo || bad != 0 || !rsp_valid) begin
            errors++;
            $display("FAIL bp_run_ignore got=%0d exp=0 tmo=%0d", bad, tmo);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({rsp_valid, req_ready, result, cout, zero, neg} !== {2'b10, e}) begin
                errors++;
                $display("FAIL bp_hold%0d got=%h exp=%h", i,
                         {rsp_valid, req_ready, result, cout, zero, neg}, {2'b10, e});
            end
        end
        rsp_r = 1'b1;
        tick();
        rsp_r = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, result, cout, zero, neg} !== {2'b01, e}) begin
            errors++;
            $display("FAIL bp_release got=%h exp=%h",
                     {rsp_valid, req_ready, result, cout, zero, neg}, {2'b01, e});
        end
        run_op(16'h8000, 16'h8001, 1'b0, 3'd1, obs, lat, tmo);
        checks++;
        if (tmo || obs !== model(16'h8000, 16'h8001, 1'b0, 3'd1)) begin
            errors++;
            $display("FAIL bp_next got=%h exp=%h", obs, model(16'h8000, 16'h8001, 1'b0, 3'd1));
        end
    endtask

    task automatic test_reset_mid_run();
        logic [18:0] obs;
        int lat, seen;
        bit tmo;
        run_op(16'h0001, 16'h0001, 1'b0, 3'd0, obs, lat, tmo);
        start_op(16'hF0F0, 16'h0F0F, 1'b0, 3'd0, tmo);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, result, cout, zero, neg} !== {1'b1, 20'd0}) begin
            errors++;
            $display("FAIL abort_state got=%h exp=%h",
                     {req_ready, rsp_valid, result, cout, zero, neg}, {1'b1, 20'd0});
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (rsp_valid) seen++; end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_rsp got=%0d exp=0", seen);
        end
        run_op(16'h1234, 16'h1111, 1'b0, 3'd0, obs, lat, tmo);
        checks++;
        if (tmo || obs !== {16'h2345, 3'b000}) begin
            errors++;
            $display("FAIL abort_fresh got=%h exp=%h", obs, {16'h2345, 3'b000});
        end
    endtask

    task automatic test_random(input logic s, input int count, input int exp_lat);
        logic [18:0] obs, e;
        logic [15:0] ra, rb;
        logic        rc;
        logic [2:0]  rop;
        int lat;
        bit tmo;
        sel = s;
        tick();
        for (int i = 0; i < count; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rop = 3'($urandom);
            if (i % 8 == 0) rb = ra;
            e = model(ra, rb, rc, rop);
            run_op(ra, rb, rc, rop, obs, lat, tmo);
            checks++;
            if (tmo || obs !== e || lat != exp_lat) begin
                errors++;
                $display("FAIL rand_step%0d_%0d got=%h/%0d exp=%h/%0d op=%0d a=%h b=%h c=%b",
                         s ? 4 : 1, i, obs, lat, e, exp_lat, rop, ra, rb, rc);
            end
        end
        sel = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_backpressure();
        test_reset_mid_run();
        test_random(1'b0, 20, 16);
        test_random(1'b1, 60, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_alu_responder.md
Name: serial_alu_responder

Overview:
- Multi-cycle, bit-serial ALU that sits on the responder side of the operand/opcode interface: {a, b, cin, opc} in, {result, cout, zero, neg} out.
- Requests are accepted with a valid/ready handshake. The block processes STEP bits per cycle, LSB first, and returns the result with a second valid/ready handshake.
- It is the area-reduced drop-in for the combinational ALU behind any initiator (bench, sequencer, datapath controller).

Parameters:
- WIDTH, 16, operand/result width.
- STEP, 1, bits processed per RUN cycle; must divide WIDTH (elaboration-time assertion).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  initiator presents a request
- req_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry/borrow in
- opc  in  3  opcode
- rsp_valid  out  1  result available
- rsp_ready  in  1  initiator takes the result
- result  out  WIDTH  ALU result
- cout  out  1  carry out
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]

Behaviour:
- Clocking: single clock. Reset is synchronous and active-high.
- Opcodes:
  - 0 ADD: a+b+cin
  - 1 SUB: a+~b+!cin, i.e. a-b-cin; cout=1 means no borrow
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT a
  - 6 XNOR
  - 7 reserved: result 0, zero=1
  - cout=0 for opcodes 2-7.
- States:
  - IDLE: req_ready=1.
  - RUN: processing.
  - DONE: rsp_valid=1.
- Reset: state IDLE; result, cout, zero, neg, rsp_valid = 0. req_ready is 0 while rst=1 and 1 in the first cycle after rst is deasserted.
- Accept: edge where state==IDLE && req_valid. This latches a, b, cin, opc into shift registers, loads carry=(opc==SUB ? !cin : cin), sets cnt=0, and moves to RUN. Inputs are don't-care after acceptance.
- RUN, each cycle:
  - The slice consumes the low STEP bits of a and b plus the carry.
  - The produced STEP bits shift into the top of the result register (MSB-first fill, so the LSB ends in bit 0 after WIDTH/STEP steps).
  - carry updates; zero_acc &= (slice bits==0); cnt++.
- Completion: on the edge where cnt==WIDTH/STEP-1, go to DONE and drive outputs: result, cout=carry (arith ops only), zero=zero_acc, neg=result MSB.
- Latency: request accepted at edge t0 gives rsp_valid=1 after edge t0+WIDTH/STEP (16 cycles at defaults).
- DONE: result and flags are held stable while rsp_valid=1 && !rsp_ready (backpressure of any length). On the edge with rsp_ready=1, go to IDLE and clear rsp_valid. result and flags keep their last value.
- No overlap and no bypass: one request is in flight at a time, so throughput is 1 per WIDTH/STEP+2 cycles minimum.
- req_valid while not IDLE is ignored: no acceptance, no side effect.
- rsp_ready while not DONE is ignored.
- rst in RUN or DONE aborts the in-flight operation: return to IDLE, clear all outputs, issue no response.
- Arithmetic wraps modulo 2^WIDTH. Overflow is not flagged.

Decomposition:
- Package alu_pkg:
  - opcode enum typedef (ADD..RSVD, 3 bits)
  - FSM state enum (IDLE, RUN, DONE)
  - function is_arith(opc)
- Sub-module alu_slice: purely combinational, STEP-bit. Inputs a_s, b_s, carry_in, opc; outputs r_s, carry_out. Instantiated once in the top, which owns the FSM, counter, shift registers and flags.

Test Plan:
- ADD a=16'hFFFF, b=16'h0001, cin=0 -> result 16'h0000, cout=1, zero=1, neg=0; rsp_valid rises exactly 16 cycles after accept.
- SUB a=16'h0003, b=16'h0005, cin=0 -> result 16'hFFFE, cout=0 (borrow), neg=1, zero=0. Repeat with cin=1 -> result 16'hFFFD.
- Logic ops a=16'hFF00, b=16'h0FF0: AND->16'h0F00, OR->16'hFFF0, XOR->16'hF0F0, NOT->16'h00FF, XNOR->16'h0F0F, opc=7->16'h0000 zero=1; cout=0 for all.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> result/flags stable and req_ready=0 throughout. Pulse a new req_valid during RUN -> ignored. After rsp_ready, the next request is accepted and answered correctly.
- Reset mid-RUN at cnt=7 -> next cycle IDLE, all outputs 0, no rsp_valid. A fresh ADD 16'h1234+16'h1111 then returns 16'h2345.
- STEP=4 build, randomized {a, b, cin, opc} stream against a reference model -> all match, latency 4 cycles.
